// File: rtl/a1000_pkg.sv
`default_nettype none
// ============================================================================
// Module   : a1000_pkg
// Purpose  : Shared constants for the A1000 clock/reset block. Holds the
//            master clock rate and the per-phase masks that decode the
//            3-bit phase counter into the system clock family.
// Revision : 1.0 - initial release
// ============================================================================
package a1000_pkg;

  // Master clock frequency in Hz (28.63636 MHz).
  localparam int unsigned CLK_HZ = 28_636_360;

  // Phase masks: bit p holds the clock level while the phase counter equals p.
  localparam logic [7:0] PH_C7M  = 8'b0011_0011;  // high in p {0,1,4,5}
  localparam logic [7:0] PH_CDAC = 8'b0110_0110;  // high in p {1,2,5,6}
  localparam logic [7:0] PH_C1   = 8'b1111_0000;  // low in p {0,1,2,3}
  localparam logic [7:0] PH_C3   = 8'b1100_0011;  // low in p {2,3,4,5}

  // Phase counter type; wraps 7 -> 0 naturally.
  typedef logic [2:0] phase_t;

endpackage
`default_nettype wire

// File: rtl/a1000_sync.sv
`default_nettype none
// ============================================================================
// Module   : a1000_sync
// Purpose  : N-flop synchronizer with a selectable reset value. Brings an
//            asynchronous level into the CLK domain with STAGES cycles of
//            latency.
// Revision : 1.0 - initial release
// ============================================================================
module a1000_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input in at the bottom; the oldest sample sits at the top.
  assign sync_d = (sync_q << 1) | STAGES'(d_i);

  // Synchronizer chain, preset to the idle level while in reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/a1000_clock_reset.sv
`default_nettype none
// ============================================================================
// Module   : a1000_clock_reset
// Purpose  : A1000 clock and reset generator. Divides the 28.63636 MHz master
//            clock into C7M/CDAC (7.16 MHz) and _C1/_C3 (3.58 MHz), drives
//            the open-drain system reset _RST with stretching, and
//            synchronizes the _OVR override request.
// Revision : 1.0 - initial release
// ============================================================================
module a1000_clock_reset
  import a1000_pkg::*;
#(
  parameter int unsigned RESET_STRETCH = 16,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic VCC_5V,
  input  logic GND,
  input  logic _OVR,
  inout  wire  _RST,
  output logic _C1,
  output logic _C3,
  output logic C7M,
  output logic CDAC,
  output logic OVR
);

  localparam int unsigned      CNT_W        = $clog2(RESET_STRETCH + 1);
  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(RESET_STRETCH);

  // Phase counter and registered clock decode.
  phase_t p_q;
  phase_t p_d;
  logic   c7m_q;
  logic   cdac_q;
  logic   c1_n_q;
  logic   c3_n_q;

  // Reset generation.
  logic [CNT_W-1:0]       stretch_q;
  logic [CNT_W-1:0]       stretch_d;
  logic [SYNC_STAGES-1:0] drive_hist_q;
  logic [SYNC_STAGES-1:0] drive_hist_d;
  logic                   rst_sense;
  logic                   ext_low;
  logic                   cause;
  logic                   c7m_rise;
  logic                   rst_drive;
  logic                   ovr_sync;

  assign p_d = p_q + 3'd1;

  // Free-running phase counter; only the hard reset stops it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  // Decode the next phase so every clock output changes on the same edge
  // as the counter, straight from a flop (glitch-free, matched skew).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      c7m_q  <= PH_C7M[0];
      cdac_q <= PH_CDAC[0];
      c1_n_q <= PH_C1[0];
      c3_n_q <= PH_C3[0];
    end else begin
      c7m_q  <= PH_C7M[p_d];
      cdac_q <= PH_CDAC[p_d];
      c1_n_q <= PH_C1[p_d];
      c3_n_q <= PH_C3[p_d];
    end
  end

  assign C7M  = c7m_q;
  assign CDAC = cdac_q;
  assign _C1  = c1_n_q;
  assign _C3  = c3_n_q;

  // Read back the reset pin; idles high so reset exit is not seen as external.
  a1000_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_rst_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (_RST),
    .q_o   (rst_sense)
  );

  // Override request synchronizer; the output is the active-high sense.
  a1000_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_ovr_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (_OVR),
    .q_o   (ovr_sync)
  );

  assign OVR = ~ovr_sync;

  // A low read-back only counts as external if we did not drive the pin in
  // any cycle the synchronizer could still be reflecting. Using the drive
  // history (not the live drive) keeps the loop free of combinational paths
  // and stops the pin from latching itself low after our own release.
  assign ext_low  = ~rst_sense & ~(|drive_hist_q);
  assign cause    = ~VCC_5V | GND | ext_low;
  // C7M rises on the p 3->4 and 7->0 transitions.
  assign c7m_rise = (p_q == 3'd3) || (p_q == 3'd7);

  // Stretch next-state: a live cause reloads (wins over a coincident C7M
  // edge); otherwise count down once per C7M rising edge.
  always_comb begin
    stretch_d = stretch_q;
    if (cause) begin
      stretch_d = STRETCH_LOAD;
    end else if (c7m_rise && (stretch_q != '0)) begin
      stretch_d = stretch_q - CNT_W'(1);
    end
  end

  assign rst_drive    = (stretch_q != '0) | cause;
  assign drive_hist_d = (drive_hist_q << 1) | SYNC_STAGES'(rst_drive);

  // Stretch counter and drive history; hard reset counts as driving.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stretch_q    <= STRETCH_LOAD;
      drive_hist_q <= '1;
    end else begin
      stretch_q    <= stretch_d;
      drive_hist_q <= drive_hist_d;
    end
  end

  // Open-drain: pull low or release to the external pull-up.
  assign _RST = rst_drive ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_a1000_clock_reset.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_a1000_clock_reset
// Purpose  : Self-checking bench for a1000_clock_reset: reset values, clock
//            phasing and period, reset stretch, external reset, supply
//            faults and override synchronization.
// Revision : 1.0 - initial release
// ============================================================================
module tb_a1000_clock_reset;

  localparam int STRETCH = 16;
  localparam int SYNC    = 2;

  // Expected clock levels for p = 0..7 (leftmost is p = 0).
  localparam bit [0:7] T_C7M  = 8'b1100_1100;
  localparam bit [0:7] T_CDAC = 8'b0110_0110;
  localparam bit [0:7] T_C1   = 8'b0000_1111;
  localparam bit [0:7] T_C3   = 8'b1100_0011;

  typedef struct {
    int         edge_n;
    logic [5:0] v;      // {C7M, CDAC, _C1, _C3, _RST, OVR}
  } exp_t;

  exp_t sb_q[$];

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic vcc     = 1'b1;
  logic gnd     = 1'b0;
  logic ovr_n   = 1'b1;
  logic tb_pull = 1'b0;
  wire  rst_bus;
  wire  c1_n, c3_n, c7m, cdac, ovr;

  int n     = 0;   // CLK edges since the last RST release
  int tests = 0;
  int fails = 0;

  a1000_clock_reset #(
    .RESET_STRETCH (STRETCH),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .VCC_5V (vcc),
    .GND    (gnd),
    ._OVR   (ovr_n),
    ._RST   (rst_bus),
    ._C1    (c1_n),
    ._C3    (c3_n),
    .C7M    (c7m),
    .CDAC   (cdac),
    .OVR    (ovr)
  );

  // Board pull-up plus the bench's own open-drain driver on _RST.
  pullup (rst_bus);
  assign rst_bus = tb_pull ? 1'b0 : 1'bz;

  always #17.5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  function automatic logic [5:0] expv(int k, logic rstn, logic ovr_e);
    int p;
    p = k % 8;
    return {T_C7M[p], T_CDAC[p], T_C1[p], T_C3[p], rstn, ovr_e};
  endfunction

  // Edge at which _RST is released when the last reload happened at edge e:
  // C7M rises on every edge index divisible by 4, and the stretch needs
  // STRETCH of those after the reload.
  function automatic int release_edge(int e);
    return (e - (e % 4) + 4) + 4 * (STRETCH - 1);
  endfunction

  task automatic push(int k, logic rstn, logic ovr_e);
    exp_t e;
    e.edge_n = k;
    e.v      = expv(k, rstn, ovr_e);
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    #100;
    obs = {c7m, cdac, c1_n, c3_n, rst_bus, ovr};
    tests++;
    if (obs !== expv(0, 1'b0, 1'b0)) begin
      fails++;
      $display("FAIL reset_values: got %b want %b", obs, expv(0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_reset_stretch();
    exp_t       e;
    logic [5:0] obs;
    for (int k = 1; k <= 80; k++) push(k, (k >= release_edge(0)), 1'b0);
    for (int k = 1; k <= 80; k++) begin
      step();
      e   = sb_q.pop_front();
      obs = {c7m, cdac, c1_n, c3_n, rst_bus, ovr};
      tests++;
      if (obs !== e.v) begin
        fails++;
        $display("FAIL reset_stretch edge %0d: got %b want %b", e.edge_n, obs, e.v);
      end
    end
  endtask

  task automatic test_c1_period();
    int   rises = 0;
    int   highs = 0;
    logic prev;
    prev = c1_n;
    for (int k = 0; k < 8000; k++) begin
      step();
      if (c1_n && !prev) rises++;
      if (c1_n) highs++;
      prev = c1_n;
    end
    tests++;
    if (rises !== 1000) begin
      fails++;
      $display("FAIL c1_rises: got %0d want 1000", rises);
    end
    tests++;
    if (highs !== 4000) begin
      fails++;
      $display("FAIL c1_duty: got %0d high cycles want 4000", highs);
    end
  endtask

  task automatic test_external();
    exp_t       e;
    logic [5:0] obs;
    int         e0;
    int         rel;
    int         len;
    e0  = n;
    // Detected after the synchronizer depth, reloaded on the following edge.
    rel = release_edge(e0 + SYNC + 1);
    len = rel - e0 + 20;
    tb_pull = 1'b1;
    for (int k = 1; k <= len; k++)
      push(e0 + k, ((k <= 20) || (e0 + k < rel)) ? 1'b0 : 1'b1, 1'b0);
    for (int k = 1; k <= len; k++) begin
      step();
      e   = sb_q.pop_front();
      obs = {c7m, cdac, c1_n, c3_n, rst_bus, ovr};
      tests++;
      if (obs !== e.v) begin
        fails++;
        $display("FAIL ext_reset edge %0d: got %b want %b", e.edge_n, obs, e.v);
      end
      if (k == 20) tb_pull = 1'b0;
    end
  endtask

  task automatic test_cause(input bit use_gnd, input string name);
    exp_t       e;
    logic [5:0] obs;
    int         rel;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n   = 0;
    // Counter reaches 5 after edge 44; fault held over edges 46..55.
    rel = release_edge(55);
    for (int k = 1; k <= 130; k++) push(k, (k >= rel), 1'b0);
    for (int k = 1; k <= 130; k++) begin
      step();
      e   = sb_q.pop_front();
      obs = {c7m, cdac, c1_n, c3_n, rst_bus, ovr};
      tests++;
      if (obs !== e.v) begin
        fails++;
        $display("FAIL %s edge %0d: got %b want %b", name, e.edge_n, obs, e.v);
      end
      if (k == 45) begin
        if (use_gnd) gnd = 1'b1;
        else         vcc = 1'b0;
      end
      if (k == 55) begin
        gnd = 1'b0;
        vcc = 1'b1;
      end
    end
  endtask

  task automatic test_ovr();
    exp_t       e;
    logic [5:0] obs;
    int         e0;
    e0    = n;
    ovr_n = 1'b0;
    for (int k = 1; k <= 12; k++)
      push(e0 + k, 1'b1, ((k >= SYNC) && (k < 6 + SYNC)));
    for (int k = 1; k <= 12; k++) begin
      step();
      e   = sb_q.pop_front();
      obs = {c7m, cdac, c1_n, c3_n, rst_bus, ovr};
      tests++;
      if (obs !== e.v) begin
        fails++;
        $display("FAIL ovr_sync edge %0d: got %b want %b", e.edge_n, obs, e.v);
      end
      if (k == 6) ovr_n = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    n   = 0;
    test_reset_stretch();
    test_c1_period();
    test_external();
    test_cause(1'b0, "vcc_drop");
    test_cause(1'b1, "gnd_fault");
    test_ovr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
